// File: rtl/imm_gen_pipe_pkg.sv
// Purpose: shared opcode constants and immediate format class for the decode-stage immediate generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        Z    = 3'd6
    } imm_fmt_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purpose: combinational immediate extraction and format classification from one instruction word.
// Latency: 0 cycles.
// Backpressure: none (pure function of inst).
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    logic [31:0] raw;
    imm_fmt_t    fmt;

    always_comb begin
        raw     = '0;
        fmt     = NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OP_IMM, LOAD, JALR: begin
                fmt = I;
                raw = {{20{inst[31]}}, inst[31:20]};
            end
            STORE: begin
                fmt = S;
                raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            BRANCH: begin
                fmt = B;
                raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt = U;
                raw = {inst[31:12], 12'b0};
            end
            JAL: begin
                fmt = J;
                raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            SYSTEM: begin
                if (ZIMM_EN && inst[14]) begin
                    fmt = Z;
                    raw = {27'b0, inst[19:15]};
                end
            end
            OP: begin
                fmt = NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // zimm has bit 31 clear, so one sign-extending widen serves every format
    assign imm     = XLEN'(signed'(raw));
    assign imm_fmt = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: registered immediate generator with a 2-entry (output + skid) valid/ready pipeline.
// Latency: 1 cycle from accept to out_valid when the output register is free or draining.
// Backpressure: in_ready is registered and drops the cycle after the skid entry fills.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 32,
    parameter bit ZIMM_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic             skid_vld;
    logic [31:0]      skid_inst;
    logic [TAG_W-1:0] skid_tag;

    logic             take_in;
    logic             load_out;
    logic [31:0]      src_inst;
    logic [TAG_W-1:0] src_tag;
    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;

    assign in_ready = ~skid_vld;
    assign take_in  = in_valid & ~skid_vld;
    assign load_out = ~out_valid | out_ready;

    // skid holds the older entry, so it always wins the output register
    assign src_inst = skid_vld ? skid_inst : inst;
    assign src_tag  = skid_vld ? skid_tag  : in_tag;

    imm_decode #(
        .XLEN    (XLEN),
        .ZIMM_EN (ZIMM_EN)
    ) u_decode (
        .inst    (src_inst),
        .imm     (dec_imm),
        .imm_fmt (dec_fmt),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
            skid_inst <= '0;
            skid_tag  <= '0;
            imm       <= '0;
            imm_fmt   <= NONE;
            illegal   <= 1'b0;
            out_tag   <= '0;
        end else if (load_out) begin
            out_valid <= skid_vld | take_in;
            skid_vld  <= 1'b0;
            if (skid_vld || take_in) begin
                imm     <= dec_imm;
                imm_fmt <= dec_fmt;
                illegal <= dec_illegal;
                out_tag <= src_tag;
            end
        end else if (take_in) begin
            skid_vld  <= 1'b1;
            skid_inst <= inst;
            skid_tag  <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboarded bench driving a 32-bit/zimm and a 64-bit/no-zimm instance from shared stimulus.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] inst, in_tag;

    logic        in_ready_a, out_valid_a, ill_a;
    logic [31:0] imm_a, tag_a;
    logic [2:0]  fmt_a;
    logic        in_ready_b, out_valid_b, ill_b;
    logic [63:0] imm_b;
    logic [31:0] tag_b;
    logic [2:0]  fmt_b;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZIMM_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .inst(inst), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
        .imm(imm_a), .imm_fmt(fmt_a), .illegal(ill_a), .out_tag(tag_a));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ZIMM_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .inst(inst), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .imm_fmt(fmt_b), .illegal(ill_b), .out_tag(tag_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t        qa[$], qb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tag_ctr = 32'h100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: immediate value as an integer built from the field weights of each format
    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] tag,
                                     input bit x64, input bit zen);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'(NONE);
        e.ill = 1'b0;
        e.tag = tag;
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.fmt = 3'(I);
                v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
            end
            7'b0100011: begin
                e.fmt = 3'(S);
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd4096 : 64'sd0);
            end
            7'b1100011: begin
                e.fmt = 3'(B);
                v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                    - (w[31] ? 64'sd4096 : 64'sd0);
            end
            7'b0110111, 7'b0010111: begin
                e.fmt = 3'(U);
                v = longint'(w[30:12]) * 4096 - (w[31] ? 64'sd2147483648 : 64'sd0);
            end
            7'b1101111: begin
                e.fmt = 3'(J);
                v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                    - (w[31] ? 64'sd1048576 : 64'sd0);
            end
            7'b1110011: begin
                if (zen && w[14]) begin
                    e.fmt = 3'(Z);
                    v = longint'(w[19:15]);
                end
            end
            7'b0110011: ;
            default: e.ill = 1'b1;
        endcase
        e.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
        return e;
    endfunction

    // Monitor: flush/reset empty the model; otherwise pop on output transfer, push on input accept
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [63:0] prev_imm_a, prev_imm_b;
    logic [31:0] prev_tag_a, prev_tag_b;
    exp_t        e;

    always @(negedge clk) begin
        if (reset || flush) begin
            qa.delete();
            qb.delete();
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_stable_valid", out_valid_a, 1);
                chk("a_stable_imm", imm_a, prev_imm_a);
                chk("a_stable_tag", tag_a, prev_tag_a);
            end
            if (stall_b) begin
                chk("b_stable_valid", out_valid_b, 1);
                chk("b_stable_imm", imm_b, prev_imm_b);
                chk("b_stable_tag", tag_b, prev_tag_b);
            end
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_imm", imm_a, e.imm);
                    chk("a_fmt", fmt_a, e.fmt);
                    chk("a_illegal", ill_a, e.ill);
                    chk("a_tag", tag_a, e.tag);
                end
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_imm", imm_b, e.imm);
                    chk("b_fmt", fmt_b, e.fmt);
                    chk("b_illegal", ill_b, e.ill);
                    chk("b_tag", tag_b, e.tag);
                end
            end
            if (in_valid && in_ready_a) qa.push_back(ref_dec(inst, in_tag, 1'b0, 1'b1));
            if (in_valid && in_ready_b) qb.push_back(ref_dec(inst, in_tag, 1'b1, 1'b0));
            stall_a    = out_valid_a && !out_ready;
            stall_b    = out_valid_b && !out_ready;
            prev_imm_a = {32'b0, imm_a};
            prev_imm_b = imm_b;
            prev_tag_a = tag_a;
            prev_tag_b = tag_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_inst(input logic [31:0] w);
        bit ok;
        int k;
        ok       = 1'b0;
        k        = 0;
        in_valid = 1'b1;
        inst     = w;
        in_tag   = tag_ctr;
        while (!ok && k < 100) begin
            @(negedge clk);
            ok = in_ready_a;
            step();
            k++;
        end
        if (!ok) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_out_valid_a"}, out_valid_a, 0);
        chk({tag, "_in_ready_a"}, in_ready_a, 1);
        chk({tag, "_imm_a"}, imm_a, 0);
        chk({tag, "_fmt_a"}, fmt_a, 3'(NONE));
        chk({tag, "_illegal_a"}, ill_a, 0);
        chk({tag, "_tag_a"}, tag_a, 0);
        chk({tag, "_out_valid_b"}, out_valid_b, 0);
        chk({tag, "_in_ready_b"}, in_ready_b, 1);
        chk({tag, "_imm_b"}, imm_b, 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [12];
        logic [31:0] w;
        int          idx;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011, 7'b1111111, 7'b0000000};
        w   = $urandom;
        idx = $urandom_range(0, 12);
        if (idx < 12) w[6:0] = ops[idx];
        return w;
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset_values("reset");
        step();

        // Directed formats with downstream always ready
        out_ready = 1'b1;
        push_inst(32'hFFF0_0093);
        chk("addi_latency", out_valid_a, 1);
        chk("addi_in_ready", in_ready_a, 1);
        push_inst(32'hFE11_2E23);
        push_inst(32'hFE00_0CE3);
        push_inst(32'h8000_00B7);
        push_inst(32'h0010_006F);
        push_inst(32'h0000_007F);
        push_inst(32'h000F_D073);
        push_inst(32'h0000_0033);
        push_inst(32'h0000_0073);
        repeat (4) step();

        // Stall: two accepted, third held off until the pipe drains
        out_ready = 1'b0;
        push_inst(32'h0010_0093);
        push_inst(32'h0020_0093);
        chk("stall_held", qa.size(), 2);
        in_valid = 1'b1; inst = 32'h0030_0093; in_tag = tag_ctr;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready_a, 0);
            chk("stall_out_valid", out_valid_a, 1);
            step();
        end
        out_ready = 1'b1;
        push_inst(32'h0030_0093);
        repeat (4) step();

        // Flush with skid full; the input offered in the flush cycle is dropped too
        out_ready = 1'b0;
        push_inst(32'h0040_0093);
        push_inst(32'h0050_0093);
        in_valid = 1'b1; inst = 32'h0060_0093; in_tag = tag_ctr++;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid_a, 0);
        chk("flush_in_ready", in_ready_a, 1);
        chk("flush_out_valid_b", out_valid_b, 0);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // Reset while stalled with both entries held
        out_ready = 1'b0;
        push_inst(32'h0070_0093);
        push_inst(32'hFE11_2E23);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        reset_values("midstall_reset");
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Randomised traffic, backpressure and occasional flush
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            inst      = rand_inst();
            in_tag    = tag_ctr++;
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) step();
        step();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the pipelined core.
- Accepts one instruction word plus a sideband tag per cycle over a valid/ready handshake.
- Produces the XLEN-wide immediate, its format class and an illegal-opcode flag after one register stage.
- A 2-entry skid buffer lets upstream stall cleanly without combinational ready paths; covers I/S/B/U/J formats plus CSR zimm.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64, sign extension always fills to XLEN.
- TAG_W, 32, width of the sideband tag (normally the PC), passed through unchanged.
- ZIMM_EN, 1, when 1 SYSTEM CSR-immediate forms (funct3[2]=1) yield zero-extended inst[19:15]; when 0 SYSTEM returns 0 with fmt=NONE.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  an instruction is presented.
- in_ready  output  1  block can accept; registered, high iff skid entry empty.
- inst  input  32  instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts.
- imm  output  XLEN  generated immediate.
- imm_fmt  output  3  format class (imm_fmt_t).
- illegal  output  1  opcode not in the supported set.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset, and flush (same cycle): out_valid=0, skid empty, in_ready=1, imm=0, imm_fmt=NONE, illegal=0, out_tag=0; flush has priority over any transfer in that cycle; in_valid in a flush cycle is dropped.
- Decode (combinational, opcode=inst[6:0]):
  - I (0010011, 0000011, 1100111): sext(inst[31:20]).
  - S (0100011): sext({inst[31:25],inst[11:7]}).
  - B (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U (0110111, 0010111): sext({inst[31:12],12'b0}).
  - J (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Z (1110011, funct3[2]=1, ZIMM_EN=1): zext(inst[19:15]).
  - NONE (R-type 0110011, other SYSTEM): imm=0, illegal=0.
  - Anything else: imm=0, fmt=NONE, illegal=1.
- Sext: replicate inst[31] to XLEN; for XLEN=64, U-type is sign-extended from bit 31.
- Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
- Latency: accepted instruction appears on outputs the next cycle when the output register is free or draining.
- Output register loads from skid if skid full, else from input, whenever it is empty or draining.
- Skid captures the input when a transfer-in happens while output is valid and not draining; in_ready deasserts the following cycle.
- Ordering strictly FIFO; no entry lost or duplicated.
- Output fields stable while out_valid & !out_ready.
- Simultaneous in/out transfer with skid empty: output register replaced, throughput 1/cycle.
- Reset mid-stall: all entries dropped, same values as reset.

Decomposition:
- Package imm_pkg: opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM, OP), imm_fmt_t enum {NONE, I, S, B, U, J, Z} in 3 bits.
- Sub-module imm_decode: pure combinational, parametrised by XLEN and ZIMM_EN.
- imm_gen_pipe owns the handshake, skid and output registers.

Test Plan:
- Reset, then addi x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle imm=0xFFFFFFFF, fmt=I, illegal=0; in_ready stays 1.
- sw with offset -4 (0xFE112E23) then beq offset -8 (0xFE000CE3) back-to-back -> imm 0xFFFFFFFC fmt=S, then 0xFFFFFFF8 fmt=B; tags match order.
- XLEN=64: lui 0x80000 (0x800000B7) -> imm=0xFFFFFFFF80000000 fmt=U; jal +2048 (0x0010006F) -> imm=0x800 fmt=J.
- out_ready=0 with 3 instructions offered -> 2 accepted, in_ready=0 from cycle after 2nd, outputs stable; release -> both drain in order, then 3rd accepted.
- Stalled with skid full, assert flush -> next cycle out_valid=0, in_ready=1, nothing from before flush ever emitted.
- inst=0x0000007F -> illegal=1, imm=0; csrrwi zimm=31 (0x000FD073) -> imm=31 fmt=Z (ZIMM_EN=1), imm=0 fmt=NONE (ZIMM_EN=0).
